gb_lcd_capture: RTL
===================

Name: gb_lcd_capture

Overview:
- Front-end stage between the Game Boy core's LCD pins and the HDMI converter's frame-buffer write port.
- Edge-detects the pixel latch and turns the raw hs/vs/cpl/pixel/valid stream into framed, addressed single-cycle writes for the 160x144 2-bit buffer.
- Polices line and frame length and reports frame boundaries and timing errors.
- Runs entirely in the Game Boy clock domain.

Parameters:
- WIDTH, 160, active pixels per line.
- HEIGHT, 144, active lines per frame.
- OFF_TIMEOUT, 2000000, clk cycles without a vs rising edge before the LCD is declared off (LCD_OFF_DETECT_EN only).
- FILL_SHADE, 2'd0, shade written during off-fill (LCD_OFF_DETECT_EN only).

Ports:
- clk  in  1  Game Boy clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- lcd_hs  in  1  horizontal sync from the core.
- lcd_vs  in  1  vertical sync from the core.
- lcd_cpl  in  1  pixel latch.
- lcd_pixel  in  2  pixel shade.
- lcd_valid  in  1  pixel valid.
- wr_en  out  1  one-cycle frame-buffer write strobe.
- wr_addr  out  15  linear address y*WIDTH+x.
- wr_x  out  8  pixel column of the current write.
- wr_y  out  8  pixel row of the current write.
- wr_data  out  2  shade to write.
- frame_start  out  1  pulse on an accepted vs rising edge.
- frame_done  out  1  pulse when line HEIGHT-1 completes.
- err_short_line  out  1  pulse when hs closes a partial line.
- err_short_frame  out  1  pulse when vs arrives before frame_done.
- lcd_off  out  1  level; LCD declared off.

Behaviour:
- Reset (asynchronous, active-high): every output 0; x=y=0; addr counter 0; state SYNC_WAIT.
- Edge detect: register lcd_hs, lcd_vs, and (lcd_cpl & lcd_valid).
- accept = (lcd_cpl & lcd_valid) & ~previous. The shade is sampled from lcd_pixel in the accept cycle.
- hs_rise and vs_rise are rising edges of the respective registered inputs.
- Write latency: wr_en, wr_addr, wr_x, wr_y and wr_data are registered and appear 1 cycle after accept. wr_en is high for exactly one cycle per write. The other write outputs hold their values between writes.
- wr_addr is kept as an incrementing counter; no multiplier is used.
- SYNC_WAIT: accepts and hs edges are ignored. vs_rise moves to ACTIVE.
- ACTIVE, per accept: write at (x,y), then x++ and addr++.
  - Last column (x==WIDTH-1): x<=0 and y++.
  - If y was HEIGHT-1: pulse frame_done, go to FRAME_END.
- ACTIVE, per hs_rise:
  - If x!=0: pulse err_short_line, x<=0, y++, and addr jumps to the next line start. If y was HEIGHT-1: pulse frame_done, go to FRAME_END.
  - If x==0: no action (hs following an auto-wrap).
- FRAME_END: accepts and hs edges are ignored. vs_rise enters ACTIVE.
- vs_rise in any state: x=y=addr=0, state ACTIVE, frame_start pulse. If the prior state was ACTIVE, also pulse err_short_frame.
- Simultaneous events:
  - vs_rise and accept in the same cycle: vs is applied first, then the pixel is written at (0,0) and x becomes 1.
  - hs_rise and accept with x!=0: the pixel is written at the current x, then the line closes once. No double y increment, including when the pixel was at WIDTH-1. err_short_line is pulsed only if that pixel was not at WIDTH-1.
- All pulses are exactly 1 cycle wide.
- Reset asserted mid-frame or mid-write aborts immediately to the reset state. No partial write strobe is emitted.

Optional Feature:
- Macro: LCD_OFF_DETECT_EN.
- With the macro defined:
  - A cycle counter clears on every vs_rise and saturates at OFF_TIMEOUT.
  - When the counter reaches OFF_TIMEOUT: lcd_off=1, enter state FILL.
  - FILL writes FILL_SHADE to addresses 0..WIDTH*HEIGHT-1, one per cycle, with wr_x/wr_y tracking the address. After the last address, state becomes SYNC_WAIT with lcd_off held.
  - vs_rise during FILL or SYNC_WAIT aborts the fill, clears lcd_off, and starts a frame as normal.
- Without the macro: no counter and no FILL state; lcd_off is tied to 0.

Test Plan:
- Reset, then 5 accepts with no vs -> wr_en never asserts; state stays SYNC_WAIT.
- vs pulse, then 160x144 accepts with hs after each line -> 23040 writes, addresses 0..23039 in order, each write 1 cycle after its accept. frame_done is a single pulse 1 cycle after the final accept; no error pulses.
- vs, 100 accepts, hs -> err_short_line pulses once. The next accept writes wr_x=0, wr_y=1, wr_addr=160.
- vs, 10 full lines, vs -> err_short_frame and frame_start pulse in the same cycle. The next accept writes address 0.
- vs_rise and accept in the same cycle, pixel=3 -> write at addr 0 with data 3; the following accept writes addr 1. Separately, hs_rise together with an accept at x=159 -> y increments once and err_short_line stays 0.
- With LCD_OFF_DETECT_EN and OFF_TIMEOUT=1000: idle 1000 cycles -> lcd_off=1 and 23040 consecutive FILL_SHADE writes. A vs_rise at fill write 500 -> fill stops, lcd_off=0, frame_start pulses.

Source files
------------

// File: rtl/gb_lcd_capture.sv
// gb_lcd_capture: turns the Game Boy LCD pin stream (hs/vs/cpl/pixel/valid)
// into single-cycle, addressed writes for a WIDTH x HEIGHT 2-bit frame buffer.
// It also polices line and frame length.
// Edges are found by comparing each input against its value one clock earlier,
// so a pixel accept, an hs rise and a vs rise all act in the cycle in which the
// pin changes. Write outputs follow one clock later.
// Optional feature: define LCD_OFF_DETECT_EN to enable LCD-off detection.
// After OFF_TIMEOUT cycles without a vs rise, the block clears the buffer to
// FILL_SHADE.
module gb_lcd_capture #(
    parameter int         WIDTH       = 160,
    parameter int         HEIGHT      = 144,
    parameter int         OFF_TIMEOUT = 2000000,
    parameter logic [1:0] FILL_SHADE  = 2'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lcd_hs,
    input  logic        lcd_vs,
    input  logic        lcd_cpl,
    input  logic [1:0]  lcd_pixel,
    input  logic        lcd_valid,
    output logic        wr_en,
    output logic [14:0] wr_addr,
    output logic [7:0]  wr_x,
    output logic [7:0]  wr_y,
    output logic [1:0]  wr_data,
    output logic        frame_start,
    output logic        frame_done,
    output logic        err_short_line,
    output logic        err_short_frame,
    output logic        lcd_off
);

    localparam logic [7:0]  X_LAST = 8'(WIDTH - 1);
    localparam logic [7:0]  Y_LAST = 8'(HEIGHT - 1);
    localparam logic [14:0] LINE_W = 15'(WIDTH);

    typedef enum logic [1:0] {
        SYNC_WAIT = 2'd0,
        ACTIVE    = 2'd1,
`ifdef LCD_OFF_DETECT_EN
        FRAME_END = 2'd2,
        FILL      = 2'd3
`else
        FRAME_END = 2'd2
`endif
    } state_t;

    state_t      state_q, state_d;
    logic        hs_q, vs_q, lat_q;
    logic [7:0]  x_q, x_d, y_q, y_d;
    logic [14:0] addr_q, addr_d;
    logic        wr_en_q, wr_en_d;
    logic [14:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_x_q, wr_x_d, wr_y_q, wr_y_d;
    logic [1:0]  wr_data_q, wr_data_d;
    logic        fstart_q, fstart_d, fdone_q, fdone_d;
    logic        esl_q, esl_d, esf_q, esf_d;
    logic        accept, hs_rise, vs_rise;

    assign accept  = lcd_cpl & lcd_valid & ~lat_q;
    assign hs_rise = lcd_hs & ~hs_q;
    assign vs_rise = lcd_vs & ~vs_q;

`ifdef LCD_OFF_DETECT_EN
    localparam int              CNT_W    = $clog2(OFF_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OFF_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_TRIG = CNT_W'(OFF_TIMEOUT - 1);
    localparam logic [14:0]     A_LAST   = 15'(WIDTH * HEIGHT - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             off_q, off_d;
    assign lcd_off = off_q;
`else
    assign lcd_off = 1'b0;
`endif

    // Next-state and write generation: vs first, then the pixel, then hs.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_x_d    = wr_x_q;
        wr_y_d    = wr_y_q;
        wr_data_d = wr_data_q;
        fstart_d  = 1'b0;
        fdone_d   = 1'b0;
        esl_d     = 1'b0;
        esf_d     = 1'b0;
`ifdef LCD_OFF_DETECT_EN
        off_d = off_q;
        cnt_d = (cnt_q < CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
        if (vs_rise) begin
            cnt_d = '0;
            off_d = 1'b0;
        end
`endif
        if (vs_rise) begin
            fstart_d = 1'b1;
            esf_d    = (state_q == ACTIVE);
            x_d      = '0;
            y_d      = '0;
            addr_d   = '0;
            state_d  = ACTIVE;
        end
        case (state_d)
            ACTIVE: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_d;
                    wr_x_d    = x_d;
                    wr_y_d    = y_d;
                    wr_data_d = lcd_pixel;
                    addr_d    = addr_d + 15'd1;
                    if (x_d == X_LAST) begin
                        x_d = '0;
                        if (y_d == Y_LAST) begin
                            fdone_d = 1'b1;
                            state_d = FRAME_END;
                        end
                        y_d = y_d + 8'd1;
                    end else begin
                        x_d = x_d + 8'd1;
                    end
                end
                // An hs right after an automatic wrap (x back at 0) is the normal case.
                if (hs_rise && state_d == ACTIVE && x_d != 8'd0) begin
                    esl_d  = 1'b1;
                    addr_d = addr_d + (LINE_W - {7'd0, x_d});
                    x_d    = '0;
                    if (y_d == Y_LAST) begin
                        fdone_d = 1'b1;
                        state_d = FRAME_END;
                    end
                    y_d = y_d + 8'd1;
                end
            end
`ifdef LCD_OFF_DETECT_EN
            FILL: begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_d;
                wr_x_d    = x_d;
                wr_y_d    = y_d;
                wr_data_d = FILL_SHADE;
                addr_d    = addr_d + 15'd1;
                if (x_d == X_LAST) begin
                    x_d = '0;
                    y_d = y_d + 8'd1;
                end else begin
                    x_d = x_d + 8'd1;
                end
                if (wr_addr_d == A_LAST) state_d = SYNC_WAIT;
            end
`endif
            default: ;
        endcase
`ifdef LCD_OFF_DETECT_EN
        // The counter saturates, so this fires once per silent period.
        if (!vs_rise && cnt_q == CNT_TRIG) begin
            off_d   = 1'b1;
            state_d = FILL;
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
        end
`endif
    end

    // State, edge-detect history and registered write/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SYNC_WAIT;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            lat_q     <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_x_q    <= '0;
            wr_y_q    <= '0;
            wr_data_q <= '0;
            fstart_q  <= 1'b0;
            fdone_q   <= 1'b0;
            esl_q     <= 1'b0;
            esf_q     <= 1'b0;
`ifdef LCD_OFF_DETECT_EN
            cnt_q     <= '0;
            off_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            hs_q      <= lcd_hs;
            vs_q      <= lcd_vs;
            lat_q     <= lcd_cpl & lcd_valid;
            x_q       <= x_d;
            y_q       <= y_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_x_q    <= wr_x_d;
            wr_y_q    <= wr_y_d;
            wr_data_q <= wr_data_d;
            fstart_q  <= fstart_d;
            fdone_q   <= fdone_d;
            esl_q     <= esl_d;
            esf_q     <= esf_d;
`ifdef LCD_OFF_DETECT_EN
            cnt_q     <= cnt_d;
            off_q     <= off_d;
`endif
        end
    end

    assign wr_en           = wr_en_q;
    assign wr_addr         = wr_addr_q;
    assign wr_x            = wr_x_q;
    assign wr_y            = wr_y_q;
    assign wr_data         = wr_data_q;
    assign frame_start     = fstart_q;
    assign frame_done      = fdone_q;
    assign err_short_line  = esl_q;
    assign err_short_frame = esf_q;

endmodule
